rx_buffer: RTL and testbench
============================

RX_BUFFER -- requirements
Module: rx_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; power of two, 2..16.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous reset, active-low; sampled on clk_i rising edge.
REQ-004 cr_ds_i  input  1  data size: 1 = 9 data bits, 0 = 8 data bits.
REQ-005 cr_p_i  input  2  parity config; nonzero = parity enabled.
REQ-006 frame_i  input  11  received frame from receive frontend, data bit 0 at bit 0.
REQ-007 parity_err_i  input  1  parity error of frame_i, qualified by valid_i.
REQ-008 frame_err_i  input  1  stop-bit error of frame_i, qualified by valid_i.
REQ-009 valid_i  input  1  frame-complete strobe from receive frontend.
REQ-010 rd_i  input  1  pop request; single-cycle pulse from register interface.
REQ-011 flush_i  input  1  synchronous FIFO clear.
REQ-012 clr_ovr_i  input  1  clears overrun flag.
REQ-013 rdata_o  output  9  data of head entry; zero when empty.
REQ-014 rperr_o  output  1  parity error flag of head entry; zero when empty.
REQ-015 rferr_o  output  1  frame error flag of head entry; zero when empty.
REQ-016 empty_o  output  1  FIFO holds no entry.
REQ-017 full_o  output  1  FIFO holds DEPTH entries.
REQ-018 count_o  output  $clog2(DEPTH)+1  number of stored entries.
REQ-019 ovr_o  output  1  sticky overrun flag.
REQ-020 irq_o  output  1  registered; high while FIFO is non-empty.

Function
REQ-021 Write event = rising edge of valid_i (valid_i high, previous-cycle valid_i low); a valid_i held high N cycles produces exactly one write.
REQ-022 Entry data = frame_i[8:0] when cr_ds_i=1, else {1'b0, frame_i[7:0]}, using cr_ds_i value in the write cycle.
REQ-023 Entry parity flag = parity_err_i AND (cr_p_i != 0); entry frame flag = frame_err_i.
REQ-024 Write latency: entry visible on rdata_o/rperr_o/rferr_o and empty_o low one cycle after the write event when FIFO was empty.
REQ-025 Storage: circular buffer, write and read pointers $clog2(DEPTH) bits, wrap from DEPTH-1 to 0.
REQ-026 rd_i while non-empty advances read pointer; next head visible the following cycle; count decrements by 1.
REQ-027 rd_i while empty is ignored: no pointer, count or flag change.
REQ-028 Write while full and no rd_i in same cycle: frame discarded, stored entries unchanged, ovr_o set next cycle.
REQ-029 Write and rd_i in same cycle while full: both performed, count stays DEPTH, ovr_o unchanged.
REQ-030 Write and rd_i in same cycle while non-empty and not full: both performed, count unchanged.
REQ-031 Write and rd_i in same cycle while empty: write performed, read ignored, count becomes 1.
REQ-032 ovr_o remains set until clr_ovr_i; clr_ovr_i and a new overrun in same cycle leaves ovr_o set.
REQ-033 flush_i: pointers and count zeroed next cycle; a write event in same cycle is discarded; ovr_o unaffected.
REQ-034 full_o = (count_o == DEPTH); empty_o = (count_o == 0); both combinational from registered count.
REQ-035 irq_o = registered copy of NOT empty, one cycle behind empty_o.
REQ-036 Configuration changes (cr_ds_i, cr_p_i) do not alter entries already stored.

Reset
REQ-037 While rst_i low at clock edge: pointers 0, count_o 0, empty_o 1, full_o 0, ovr_o 0, irq_o 0, rdata_o/rperr_o/rferr_o 0, valid_i edge-detect register 1 (valid_i high across reset release produces no write).
REQ-038 Reset mid-operation discards all stored entries; storage array contents need no reset.

Verification
REQ-039 cr_ds_i=0, frame_i=11'h5A5, valid_i pulse -> next cycle rdata_o=9'h0A5, empty_o=0, count_o=1, irq_o=1 one cycle later.
REQ-040 cr_ds_i=1, cr_p_i=2'b01, frame_i=11'h1FF, parity_err_i=1, frame_err_i=1 -> rdata_o=9'h1FF, rperr_o=1, rferr_o=1; same with cr_p_i=0 -> rperr_o=0.
REQ-041 DEPTH=4: write 0x11,0x22,0x33,0x44, then 0x55 -> full_o=1, ovr_o=1, pops return 11,22,33,44 then empty_o=1; clr_ovr_i -> ovr_o=0.
REQ-042 Full FIFO, write event and rd_i same cycle -> count_o stays 4, ovr_o=0, new entry emerges last after 3 more pops.
REQ-043 valid_i held high 5 cycles -> exactly one entry; rd_i on empty FIFO -> count_o stays 0.
REQ-044 3 entries stored, rst_i low one cycle mid-write -> count_o=0, empty_o=1, ovr_o=0; flush_i with concurrent write -> count_o=0.

Source files
------------

// File: rtl/rx_buffer.sv
// Receive FIFO between the UART receive frontend and the register interface.
// Captures one entry per valid_i rising edge, tracks sticky overrun and drives a registered irq.
module rx_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cr_ds_i,
  input  logic [1:0]               cr_p_i,
  input  logic [10:0]              frame_i,
  input  logic                     parity_err_i,
  input  logic                     frame_err_i,
  input  logic                     valid_i,
  input  logic                     rd_i,
  input  logic                     flush_i,
  input  logic                     clr_ovr_i,
  output logic [8:0]               rdata_o,
  output logic                     rperr_o,
  output logic                     rferr_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovr_o,
  output logic                     irq_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry layout: {frame_err, parity_err, data[8:0]}
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          valid_q;
  logic          wr_evt;
  logic          do_wr;
  logic          do_rd;
  logic          ovr_set;
  logic [10:0]   entry;
  logic [10:0]   head;
  logic          unused_frame_bits;

  // Upper frame bits carry stop/parity positions that the frontend already evaluated
  assign unused_frame_bits = ^frame_i[10:9];

  assign wr_evt  = valid_i & ~valid_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;

  assign do_rd   = rd_i & ~empty_o & ~flush_i;
  assign do_wr   = wr_evt & ~flush_i & (~full_o | rd_i);
  assign ovr_set = wr_evt & ~flush_i & full_o & ~rd_i;

  assign entry = {frame_err_i,
                  parity_err_i & (|cr_p_i),
                  cr_ds_i ? frame_i[8:0] : {1'b0, frame_i[7:0]}};

  assign head    = mem[rd_ptr];
  assign rdata_o = empty_o ? 9'd0 : head[8:0];
  assign rperr_o = ~empty_o & head[9];
  assign rferr_o = ~empty_o & head[10];

  always_ff @(posedge clk_i) begin
    if (rst_i && do_wr) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovr_o   <= 1'b0;
      irq_o   <= 1'b0;
      // Held high so a valid_i already asserted at reset release is not taken as an edge
      valid_q <= 1'b1;
    end else begin
      valid_q <= valid_i;
      irq_o   <= ~empty_o;

      if (flush_i) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + AW'(1);
        if (do_rd) rd_ptr <= rd_ptr + AW'(1);
        case ({do_wr, do_rd})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end

      if (ovr_set) begin
        ovr_o <= 1'b1;
      end else if (clr_ovr_i) begin
        ovr_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_buffer.sv
// Self-checking bench for rx_buffer: directed scenarios then random traffic,
// all compared every cycle against a queue-based reference model.
module tb_rx_buffer;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cr_ds_i = 1'b0;
  logic [1:0]  cr_p_i = 2'b00;
  logic [10:0] frame_i = '0;
  logic        parity_err_i = 1'b0;
  logic        frame_err_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        rd_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        clr_ovr_i = 1'b0;
  logic [8:0]  rdata_o;
  logic        rperr_o;
  logic        rferr_o;
  logic        empty_o;
  logic        full_o;
  logic [2:0]  count_o;
  logic        ovr_o;
  logic        irq_o;

  rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cr_ds_i(cr_ds_i), .cr_p_i(cr_p_i),
    .frame_i(frame_i), .parity_err_i(parity_err_i), .frame_err_i(frame_err_i),
    .valid_i(valid_i), .rd_i(rd_i), .flush_i(flush_i), .clr_ovr_i(clr_ovr_i),
    .rdata_o(rdata_o), .rperr_o(rperr_o), .rferr_o(rferr_o), .empty_o(empty_o),
    .full_o(full_o), .count_o(count_o), .ovr_o(ovr_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // Reference model: queue of {ferr, perr, data[8:0]}
  logic [10:0] m_q[$];
  logic        m_ovr = 1'b0;
  logic        m_prev = 1'b1;
  logic        m_irq = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic        wr;
    logic        ovf;
    logic        was_nonempty;
    logic [10:0] e;
    if (!rst_i) begin
      m_q.delete();
      m_ovr  = 1'b0;
      m_prev = 1'b1;
      m_irq  = 1'b0;
      return;
    end
    wr = valid_i && !m_prev;
    was_nonempty = (m_q.size() != 0);
    ovf = 1'b0;
    e = {frame_err_i, parity_err_i && (cr_p_i != 2'b00),
         cr_ds_i ? frame_i[8:0] : {1'b0, frame_i[7:0]}};
    if (flush_i) begin
      m_q.delete();
    end else begin
      if (wr && m_q.size() == DEPTH && !rd_i) ovf = 1'b1;
      if (rd_i && m_q.size() > 0) void'(m_q.pop_front());
      if (wr && !ovf) m_q.push_back(e);
    end
    if (ovf) m_ovr = 1'b1;
    else if (clr_ovr_i) m_ovr = 1'b0;
    m_prev = valid_i;
    m_irq  = was_nonempty;
  endtask

  task automatic check_all();
    int n;
    n = m_q.size();
    chk("count", count_o, n);
    chk("empty", empty_o, n == 0);
    chk("full", full_o, n == DEPTH);
    chk("ovr", ovr_o, m_ovr);
    chk("irq", irq_o, m_irq);
    chk("rdata", rdata_o, (n > 0) ? m_q[0][8:0] : 9'd0);
    chk("rperr", rperr_o, (n > 0) ? m_q[0][9] : 1'b0);
    chk("rferr", rferr_o, (n > 0) ? m_q[0][10] : 1'b0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
    check_all();
  endtask

  task automatic write(input logic [10:0] f, input logic pe, input logic fe);
    frame_i = f; parity_err_i = pe; frame_err_i = fe;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
  endtask

  task automatic pop();
    rd_i = 1'b1;
    tick();
    rd_i = 1'b0;
  endtask

  initial begin
    // Reset
    rst_i = 1'b0;
    tick(); tick();
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    rst_i = 1'b1;
    tick();

    // 8-bit data, upper frame bit dropped; irq follows one cycle later
    cr_ds_i = 1'b0;
    frame_i = 11'h5A5; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("d8_rdata", rdata_o, 9'h0A5);
    chk("d8_count", count_o, 1);
    chk("d8_irq_lag", irq_o, 0);
    tick();
    chk("d8_irq", irq_o, 1);
    pop(); tick();

    // 9-bit data and parity gating
    cr_ds_i = 1'b1; cr_p_i = 2'b01;
    write(11'h1FF, 1'b1, 1'b1);
    chk("d9_rdata", rdata_o, 9'h1FF);
    chk("d9_rperr", rperr_o, 1);
    chk("d9_rferr", rferr_o, 1);
    pop();
    cr_p_i = 2'b00;
    write(11'h1FF, 1'b1, 1'b1);
    chk("nopar_rperr", rperr_o, 0);
    // Config change leaves the stored entry alone
    cr_ds_i = 1'b0; cr_p_i = 2'b11;
    tick();
    chk("cfg_keep", rdata_o, 9'h1FF);
    pop(); tick();

    // Fill, overrun, drain, clear overrun
    write(11'h11, 0, 0); write(11'h22, 0, 0); write(11'h33, 0, 0); write(11'h44, 0, 0);
    write(11'h55, 0, 0);
    chk("ovf_full", full_o, 1);
    chk("ovf_flag", ovr_o, 1);
    chk("ovf_head0", rdata_o, 9'h11); pop();
    chk("ovf_head1", rdata_o, 9'h22); pop();
    chk("ovf_head2", rdata_o, 9'h33); pop();
    chk("ovf_head3", rdata_o, 9'h44); pop();
    chk("ovf_empty", empty_o, 1);
    clr_ovr_i = 1'b1; tick(); clr_ovr_i = 1'b0;
    chk("ovr_clr", ovr_o, 0);

    // Write and read together while full
    write(11'h01, 0, 0); write(11'h02, 0, 0); write(11'h03, 0, 0); write(11'h04, 0, 0);
    frame_i = 11'h0AB; valid_i = 1'b1; rd_i = 1'b1;
    tick();
    valid_i = 1'b0; rd_i = 1'b0;
    chk("wrrd_count", count_o, 4);
    chk("wrrd_ovr", ovr_o, 0);
    pop(); pop(); pop();
    chk("wrrd_last", rdata_o, 9'h0AB);
    pop(); tick();

    // valid_i held high gives one write; read on empty ignored
    frame_i = 11'h077; valid_i = 1'b1;
    repeat (5) tick();
    valid_i = 1'b0;
    chk("hold_count", count_o, 1);
    pop();
    pop();
    chk("rd_empty", count_o, 0);

    // Reset mid-operation with concurrent write
    write(11'h10, 0, 0); write(11'h20, 0, 0);
    clr_ovr_i = 1'b0;
    write(11'h30, 0, 0);
    rst_i = 1'b0; valid_i = 1'b1; frame_i = 11'h40;
    tick();
    rst_i = 1'b1; valid_i = 1'b0;
    chk("midrst_count", count_o, 0);
    chk("midrst_empty", empty_o, 1);
    tick();

    // Flush with concurrent write
    write(11'h66, 0, 0);
    flush_i = 1'b1; valid_i = 1'b1; frame_i = 11'h67;
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_count", count_o, 0);
    tick();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      valid_i      = ($urandom_range(0, 2) == 0);
      rd_i         = ($urandom_range(0, 3) == 0);
      flush_i      = ($urandom_range(0, 40) == 0);
      clr_ovr_i    = ($urandom_range(0, 15) == 0);
      rst_i        = ($urandom_range(0, 150) != 0);
      cr_ds_i      = 1'($urandom);
      cr_p_i       = 2'($urandom);
      frame_i      = 11'($urandom);
      parity_err_i = 1'($urandom);
      frame_err_i  = 1'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
